// File: rtl/dco_enc_pkg.sv
// Shared widths and types for the DCO row thermometer encoder.
package dco_enc_pkg;

    localparam int ROW_W = 16;
    localparam int CNT_W = $clog2(ROW_W + 1);

    typedef logic [ROW_W-1:0] row_word_t;
    typedef logic [CNT_W-1:0] cap_cnt_t;

endpackage

// File: rtl/popcount_tree.sv
// Combinational pairwise adder tree counting the ones in a W-bit word.
module popcount_tree
    import dco_enc_pkg::*;
#(
    parameter int W = ROW_W
) (
    input  logic [W-1:0]               bits,
    output logic [$clog2(W+1)-1:0]     sum
);

    localparam int SUM_W  = $clog2(W + 1);
    localparam int LEVELS = $clog2(W);
    localparam int LEAVES = 1 << LEVELS;

    // Heap layout: node[1] is the root, node[LEAVES+i] holds bit i (zero padded).
    logic [SUM_W-1:0] node [2*LEAVES];

    assign node[0] = '0;

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < W) begin : g_bit
            assign node[LEAVES+i] = SUM_W'(bits[i]);
        end else begin : g_pad
            assign node[LEAVES+i] = '0;
        end
    end

    for (genvar n = 1; n < LEAVES; n++) begin : g_add
        assign node[n] = node[2*n] + node[2*n+1];
    end

    assign sum = node[1];

endmodule

// File: rtl/dco_row_encoder.sv
// Registered, bubble-tolerant population count of the FLB row thermometer word,
// with a flag for codes whose ones are not contiguous from bit 0.
module dco_row_encoder
#(
    parameter int ROW_W = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] row_p,
    output logic [OUT_W-1:0] dco_cap_num,
    output logic             thrm_err
);

    import dco_enc_pkg::*;

    localparam int SUM_W = $clog2(ROW_W + 1);

    logic [SUM_W-1:0] ones_p0;
    logic [ROW_W-1:0] row_inc_p0;
    logic             bubble_p0;
    logic [OUT_W-1:0] cap_p1;
    logic             err_p1;

    popcount_tree #(.W(ROW_W)) u_popcount (
        .bits (row_p),
        .sum  (ones_p0)
    );

    // Legal codes are 2^k-1; all-ones wraps to zero on increment and stays legal.
    assign row_inc_p0 = row_p + ROW_W'(1);
    assign bubble_p0  = |(row_p & row_inc_p0);

    // Stage p0 -> p1: single capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_p1 <= '0;
            err_p1 <= 1'b0;
        end else begin
            cap_p1 <= OUT_W'(ones_p0);
            err_p1 <= bubble_p0;
        end
    end

    assign dco_cap_num = cap_p1;
    assign thrm_err    = err_p1;

endmodule

// File: tb/tb_dco_row_encoder.sv
// Scoreboard bench for dco_row_encoder: driver queues expectations, monitor checks outputs.
module tb_dco_row_encoder;
    import dco_enc_pkg::*;

    typedef struct {
        logic [31:0] cnt;
        logic        err;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    row_word_t   row_p = '0;
    logic [31:0] dco_cap_num;
    logic        thrm_err;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    dco_row_encoder #(.ROW_W(16), .OUT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_p       (row_p),
        .dco_cap_num (dco_cap_num),
        .thrm_err    (thrm_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, req);
        end
    endtask

    task automatic drive(input row_word_t v, input logic [31:0] cnt, input logic err, input string tag);
        exp_t e;
        @(negedge clk);
        row_p = v;
        e.cnt = cnt;
        e.err = err;
        e.tag = tag;
        sb_q.push_back(e);
    endtask

    // Monitor: one expectation per capture edge, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, "_cnt"}, dco_cap_num, e.cnt);
                check({e.tag, "_err"}, {31'd0, thrm_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        row_word_t   rv;
        row_word_t   rinc;
        logic [31:0] rcnt;
        int          wait_cyc;

        // Reset state, including across a clock edge while rst is held.
        #2;
        check("reset_cnt", dco_cap_num, 32'd0);
        check("reset_err", {31'd0, thrm_err}, 32'd0);
        row_p = 16'h0005;
        @(posedge clk);
        #1;
        check("reset_hold_cnt", dco_cap_num, 32'd0);
        check("reset_hold_err", {31'd0, thrm_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset mid-cycle with 0x00FF already counted.
        drive(16'h00FF, 32'd8, 1'b0, "pre_rst_00ff");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_cnt", dco_cap_num, 32'd0);
        check("async_rst_err", {31'd0, thrm_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(16'h00FF, 32'd8, 1'b0, "post_rst_00ff");

        // Every legal thermometer code, including 0 and 0xFFFF.
        for (int k = 0; k <= 16; k++) begin
            rv = row_word_t'((32'd1 << k) - 32'd1);
            drive(rv, 32'(k), 1'b0, $sformatf("legal_k%0d", k));
        end

        // Bubbled codes.
        drive(16'h0005, 32'd2,  1'b1, "bubble_0005");
        drive(16'h8000, 32'd1,  1'b1, "bubble_8000");
        drive(16'hFFFE, 32'd15, 1'b1, "bubble_fffe");
        drive(16'h0002, 32'd1,  1'b1, "bubble_0002");
        drive(16'hA5A5, 32'd8,  1'b1, "bubble_a5a5");

        // Back-to-back changes.
        drive(16'h0003, 32'd2,  1'b0, "b2b_0003");
        drive(16'h0FFF, 32'd12, 1'b0, "b2b_0fff");
        drive(16'h0000, 32'd0,  1'b0, "b2b_0000");

        // Random words against an independent reference.
        for (int i = 0; i < 1000; i++) begin
            rv   = row_word_t'($urandom);
            if (i % 4 == 0) rv = row_word_t'((32'd1 << $urandom_range(16, 0)) - 32'd1);
            rinc = rv + 16'd1;
            rcnt = 32'($countones(rv));
            drive(rv, rcnt, ((rv & rinc) != 16'd0), "rand");
        end

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dco_row_encoder.md
Name: dco_row_encoder

Overview:
- Converts the FLB's 16-bit row thermometer word (row_p) into a binary count of enabled DCO small capacitors (dco_cap_num).
- Sits between the FLB outputs and the DCO tank model. The DCO adds os_thrm ones to this count and scales the sum by SmallCap.
- Registered, bubble-tolerant population count. Also flags non-thermometer inputs.

Parameters:
- ROW_W, 16, width of the row thermometer input.
- OUT_W, 32, width of dco_cap_num. Matches the integer consumer in the DCO.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- row_p  input  ROW_W  row thermometer code from the FLB; bit 0 is the first row enabled.
- dco_cap_num  output  OUT_W  registered count of ones in row_p, unsigned, range 0..ROW_W, upper bits zero.
- thrm_err  output  1  registered flag: row_p was not a legal thermometer code.

Behaviour:
- Reset: on rst assertion, dco_cap_num=0 and thrm_err=0 immediately, with no clock needed. Both stay 0 while rst is high. The first capture happens on the first rising clk edge after rst deasserts.
- Latency: exactly 1 clk cycle. row_p sampled at edge N appears on the outputs after edge N, and holds until edge N+1.
- Count: dco_cap_num = number of 1 bits in row_p, counted regardless of position (bubble-tolerant).
  - Computed as an adder tree of zero-extended bits.
  - Width of the internal sum is clog2(ROW_W+1) = 5 bits, zero-extended to OUT_W.
  - No saturation is needed; 16 is the maximum.
- Legal thermometer code: row_p == (1<<k)-1 for some k in 0..ROW_W, i.e. ones contiguous from bit 0 with no gaps.
  - Illegal example: 16'h0005.
- thrm_err = 1 for the cycle following capture of an illegal code, else 0.
  - Check: row_p & (row_p+1) == 0, using ROW_W-bit arithmetic. All-ones wraps to 0 and is legal.
- Boundaries:
  - row_p=0 -> count 0, legal.
  - row_p=16'hFFFF -> count 16, legal.
  - Single set bit above bit 0 -> count 1, thrm_err=1.
- Reset mid-operation: outputs clear asynchronously. A pending captured value is discarded and there is no recovery state.
- No handshake. The outputs are continuously valid after reset and follow the input each cycle.
- Purely combinational input decode plus one register stage. No FSM.
- X on row_p may propagate; it is not masked.

Decomposition:
- Package dco_enc_pkg:
  - localparams ROW_W=16 and CNT_W=$clog2(ROW_W+1).
  - Typedef row_word_t = logic [ROW_W-1:0].
  - Typedef cap_cnt_t = logic [CNT_W-1:0].
- Sub-module popcount_tree (parameter W): combinational, pairwise adder tree producing a CNT_W sum. The top registers its result and the thrm_err check.

Test Plan:
- Assert rst asynchronously mid-cycle with row_p=16'h00FF already counted -> dco_cap_num drops to 0 and thrm_err to 0 immediately, without waiting for clk. After release, the next edge with row_p=16'h00FF -> 8.
- Sweep all 17 legal codes (1<<k)-1 for k=0..16, one per cycle -> dco_cap_num=k one cycle later, thrm_err=0 throughout. Covers k=16 (16'hFFFF -> 16).
- Bubbled inputs: 16'h0005 -> 2, thrm_err=1; 16'h8000 -> 1, thrm_err=1; 16'hFFFE -> 15, thrm_err=1.
- Back-to-back change 16'h0003 then 16'h0FFF on consecutive edges -> outputs 2 then 12 on consecutive cycles. Confirms 1-cycle latency and no hold-over.
- Randomized 1000 cycles of row_p, scoreboard vs $countones and the contiguity check -> exact match every cycle.
